bit_scatter64: RTL and testbench
================================

# bit_scatter64

Bit-serial write-side counterpart to the design's 64:1 single-bit selector. It accepts one bit per handshake and writes it into a 64-bit vector, either at an auto-incrementing position or at an explicit 6-bit position. When all 64 positions have been written, it presents the assembled word downstream with a valid/ready handshake. Typical use is building an 8x8 binarized feature patch from a pixel stream before it goes to the classification datapath.

## Interface
- `IWIDTH`, 64: vector width; fixed at 64 in this revision.
- `SWIDTH`, 6: position select width, log2(IWIDTH).
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `clear`, in, 1: synchronous abort; empties the buffer from any state.
- `addr_mode`, in, 1: 0 = auto-increment position, 1 = explicit position from `wr_sel`.
- `in_valid`, in, 1: input bit is offered.
- `in_bit`, in, 1: data bit.
- `wr_sel`, in, 6: target position; used only when `addr_mode`=1.
- `in_ready`, out, 1: block accepts a bit this cycle.
- `out_valid`, out, 1: `out_data` is complete and held.
- `out_data`, out, 64: assembled vector; bit k is position k.
- `out_ready`, in, 1: downstream accepts `out_data`.
- `fill_cnt`, out, 7: number of distinct positions written so far, 0..64.

## Operation
- Two states, FILL and HOLD.
- Internal registers: `data[63:0]`, `mask[63:0]` (written flags), `ptr[5:0]` (auto pointer), `fill_cnt[6:0]`.
- `in_ready` = (state==FILL) && !clear.
- `out_valid` = (state==HOLD).
- Accept event: `in_valid` && `in_ready`.
  - Target position p = `addr_mode` ? `wr_sel` : `ptr`.
  - `data[p]` <= `in_bit`.
  - `mask[p]` <= 1.
  - `fill_cnt` increments only if `mask[p]` was 0.
  - Rewriting an already-written position overwrites the data bit and leaves the count unchanged.
- Auto pointer: `ptr` increments on every accept with `addr_mode`=0 and wraps from 63 to 0. Explicit-mode accepts leave `ptr` unchanged. Modes may be mixed freely within one fill.
- FILL->HOLD: on the edge where the accept makes `fill_cnt` reach 64, i.e. `mask` becomes all ones.
- HOLD: `data` is frozen; `in_valid` is ignored (`in_ready`=0).
- HOLD->FILL: when `out_ready`=1. On that edge `data`, `mask`, `ptr` and `fill_cnt` are zeroed.
- `clear`=1, any state: next state FILL, all internal registers zeroed, any concurrent input bit dropped. `clear` takes priority over an `out_ready` handshake.
- `out_data` is driven from `data` in all states. It is only meaningful while `out_valid`=1.

## Timing
- Reset value of every output: `in_ready`=1 (state FILL), `out_valid`=0, `out_data`=0, `fill_cnt`=0.
- Reset applies asynchronously on `rst_n` falling. Operation resumes on the first rising edge after `rst_n` rises. Reset mid-fill discards all partial data.
- Write latency is 1 cycle: a bit accepted at edge n is visible in `out_data` and `fill_cnt` after edge n.
- `out_valid` rises in the cycle right after the 64th distinct write is accepted. Minimum fill is 64 cycles with `in_valid` held high.
- Output handshake: `out_data` is stable while `out_valid`=1 and `out_ready`=0. The transfer completes at the edge where both are 1.
- `in_ready` returns high in the next cycle, so back-to-back vectors cost 64 accept cycles plus 1 handshake cycle.
- No combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`. `in_ready` depends combinationally only on `clear` and state.

## Test plan
- **Auto fill.** Reset, `addr_mode`=0, stream 64 bits of 0xA5A5_F00F_1234_8001, LSB first, `out_ready`=0.
  - Response: `out_valid`=1 one cycle after the 64th accept, `out_data`=0xA5A5_F00F_1234_8001, `fill_cnt`=64, `in_ready`=0. Both outputs hold for 10 stall cycles.
- **Handshake release.** From the previous end state, pulse `out_ready` for 1 cycle.
  - Response: next cycle `out_valid`=0, `in_ready`=1, `fill_cnt`=0, `out_data`=0. Then send 64 ones: `out_data`=0xFFFF_FFFF_FFFF_FFFF.
- **Explicit duplicates.** `addr_mode`=1. Write position 5 with 1, then position 5 with 0, then positions 0..63 except 5 with 1.
  - Response: `fill_cnt` reads 1 after the second write. `out_valid` rises after the 64th distinct write. `out_data`=0xFFFF_FFFF_FFFF_FFDF.
- **Clear mid-fill.** Accept 30 bits, then assert `clear` together with `in_valid`=1.
  - Response: that bit is dropped, `fill_cnt`=0, `out_data`=0. The next 64 accepts produce a fresh vector.
- **Async reset in HOLD.** Drop `rst_n` mid-cycle while `out_valid`=1.
  - Response: outputs reach their reset values immediately, with no clock edge. After release, `in_ready`=1.
- **Input ignored in HOLD.** In HOLD, drive `in_valid`=1 with varying bits.
  - Response: `out_data` is unchanged and `fill_cnt` stays 64.

Source files
------------

// File: rtl/bit_scatter64.sv
// Bit-serial scatter buffer: collects 64 single-bit writes (auto-increment or
// explicit position) into a vector and hands the full word downstream.
module bit_scatter64 #(
  parameter int IWIDTH = 64,
  parameter int SWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              addr_mode,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic [SWIDTH-1:0] wr_sel,
  output logic              in_ready,
  output logic              out_valid,
  output logic [IWIDTH-1:0] out_data,
  input  logic              out_ready,
  output logic [SWIDTH:0]   fill_cnt
);

  typedef enum logic {FILL, HOLD} state_t;

  state_t              state_q, state_d;
  logic [IWIDTH-1:0]   data_q, data_d;
  logic [IWIDTH-1:0]   mask_q, mask_d;
  logic [SWIDTH-1:0]   ptr_q, ptr_d;
  logic [SWIDTH:0]     cnt_q, cnt_d;
  logic [SWIDTH-1:0]   pos;
  logic                accept;
  logic                fresh;

  assign in_ready  = (state_q == FILL) && !clear;
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign fill_cnt  = cnt_q;

  assign accept = in_valid && in_ready;
  assign pos    = addr_mode ? wr_sel : ptr_q;
  assign fresh  = !mask_q[pos];

  always_comb begin
    // NOTE: every next-state variable gets its hold value first, so no path
    // through the branches below leaves one unassigned (no latch inferred).
    state_d = state_q;
    data_d  = data_q;
    mask_d  = mask_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;

    if (clear) begin
      state_d = FILL;
      data_d  = '0;
      mask_d  = '0;
      ptr_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            data_d[pos] = in_bit;
            mask_d[pos] = 1'b1;
            if (!addr_mode) ptr_d = ptr_q + SWIDTH'(1);
            // Only first-time writes count; the last fresh one completes the word.
            if (fresh) begin
              cnt_d = cnt_q + (SWIDTH+1)'(1);
              if (cnt_q == (SWIDTH+1)'(IWIDTH-1)) state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = FILL;
            data_d  = '0;
            mask_d  = '0;
            ptr_d   = '0;
            cnt_d   = '0;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values computed above.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      data_q  <= '0;
      mask_q  <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_bit_scatter64.sv
// Self-checking bench for bit_scatter64: directed vector table, hand-written
// corner sequences and a randomized run against a position/flag array model.
module tb_bit_scatter64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        addr_mode;
  logic        in_valid;
  logic        in_bit;
  logic [5:0]  wr_sel;
  logic        in_ready;
  logic        out_valid;
  logic [63:0] out_data;
  logic        out_ready;
  logic [6:0]  fill_cnt;

  bit_scatter64 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .addr_mode (addr_mode),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .wr_sel    (wr_sel),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .fill_cnt  (fill_cnt)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: one data bit and one written flag per position.
  bit md [64];
  bit wr [64];
  int mptr;

  function automatic int mcount();
    int s = 0;
    for (int i = 0; i < 64; i++) s += wr[i];
    return s;
  endfunction

  function automatic logic [63:0] mdata();
    logic [63:0] v;
    for (int i = 0; i < 64; i++) v[i] = md[i];
    return v;
  endfunction

  function automatic void mreset();
    for (int i = 0; i < 64; i++) begin
      md[i] = 1'b0;
      wr[i] = 1'b0;
    end
    mptr = 0;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle: drive inputs, check in_ready, advance the model, clock, compare.
  task automatic drive(input logic c, input logic am, input logic v, input logic b,
                       input logic [5:0] s, input logic ordy);
    bit hold;
    int p;
    clear = c; addr_mode = am; in_valid = v; in_bit = b; wr_sel = s; out_ready = ordy;
    #1;
    hold = (mcount() == 64);
    check("in_ready", {63'd0, in_ready}, {63'd0, !hold && !c});
    if (c) mreset();
    else if (!hold) begin
      if (v) begin
        p = am ? int'(s) : mptr;
        md[p] = b;
        wr[p] = 1'b1;
        if (!am) mptr = (mptr + 1) % 64;
      end
    end else if (ordy) mreset();
    tick();
    check("out_valid", {63'd0, out_valid}, {63'd0, mcount() == 64});
    check("fill_cnt", {57'd0, fill_cnt}, 64'(mcount()));
    check("out_data", out_data, mdata());
  endtask

  typedef struct {
    logic        c, am, v, b;
    logic [5:0]  s;
    logic        ordy;
    logic [6:0]  exp_cnt;
    logic [63:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] pat;
    logic [63:0] rv;

    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd5,  1'b0, 7'd1, 64'h0000_0000_0000_0020};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd5,  1'b0, 7'd1, 64'h0000_0000_0000_0000};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  1'b0, 7'd2, 64'h0000_0000_0000_0001};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 6'd9,  1'b0, 7'd2, 64'h0000_0000_0000_0001};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 6'd63, 1'b0, 7'd3, 64'h8000_0000_0000_0001};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd0,  1'b0, 7'd4, 64'h8000_0000_0000_0003};
    vecs[6] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'd0,  1'b0, 7'd0, 64'h0000_0000_0000_0000};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 6'd7,  1'b0, 7'd1, 64'h0000_0000_0000_0001};

    rst_n = 1'b0; clear = 1'b0; addr_mode = 1'b0; in_valid = 1'b0;
    in_bit = 1'b0; wr_sel = 6'd0; out_ready = 1'b0;
    mreset();
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_fill_cnt", {57'd0, fill_cnt}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Directed table: duplicates, idle cycle, mixed modes, clear restarting ptr.
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].c, vecs[i].am, vecs[i].v, vecs[i].b, vecs[i].s, vecs[i].ordy);
      check($sformatf("vec%0d_cnt", i), {57'd0, fill_cnt}, {57'd0, vecs[i].exp_cnt});
      check($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0);

    // Auto fill, then stall in HOLD with inputs that must be ignored.
    pat = 64'hA5A5_F00F_1234_8001;
    for (int i = 0; i < 64; i++) begin
      if (i == 63) check("auto_not_early", {63'd0, out_valid}, 64'd0);
      drive(1'b0, 1'b0, 1'b1, pat[i], 6'd0, 1'b0);
    end
    check("auto_valid", {63'd0, out_valid}, 64'd1);
    check("auto_data", out_data, 64'hA5A5_F00F_1234_8001);
    check("auto_cnt", {57'd0, fill_cnt}, 64'd64);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'($urandom), 1'b1, 1'($urandom), 6'($urandom), 1'b0);
      check("hold_data", out_data, 64'hA5A5_F00F_1234_8001);
      check("hold_cnt", {57'd0, fill_cnt}, 64'd64);
    end

    // Handshake release, then a vector of all ones.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);
    check("rel_valid", {63'd0, out_valid}, 64'd0);
    check("rel_ready", {63'd0, in_ready}, 64'd1);
    check("rel_cnt", {57'd0, fill_cnt}, 64'd0);
    check("rel_data", out_data, 64'd0);
    for (int i = 0; i < 64; i++) drive(1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0);
    check("ones_data", out_data, 64'hFFFF_FFFF_FFFF_FFFF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);

    // Explicit duplicates at position 5.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 6'd5, 1'b0);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 6'd5, 1'b0);
    check("dup_cnt", {57'd0, fill_cnt}, 64'd1);
    for (int p = 0; p < 64; p++) begin
      if (p == 63) check("dup_not_early", {63'd0, out_valid}, 64'd0);
      if (p != 5) drive(1'b0, 1'b1, 1'b1, 1'b1, 6'(p), 1'b0);
    end
    check("dup_valid", {63'd0, out_valid}, 64'd1);
    check("dup_data", out_data, 64'hFFFF_FFFF_FFFF_FFDF);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1);

    // Clear mid-fill with a concurrent bit, then a fresh random vector.
    for (int i = 0; i < 30; i++) drive(1'b0, 1'b0, 1'b1, 1'($urandom), 6'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0);
    check("clr_cnt", {57'd0, fill_cnt}, 64'd0);
    check("clr_data", out_data, 64'd0);
    rv = {$urandom, $urandom};
    for (int i = 0; i < 64; i++) drive(1'b0, 1'b0, 1'b1, rv[i], 6'd0, 1'b0);
    check("clr_fresh_data", out_data, rv);
    check("clr_fresh_valid", {63'd0, out_valid}, 64'd1);

    // Asynchronous reset while holding a full word.
    clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    mreset();
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_ready", {63'd0, in_ready}, 64'd1);
    check("arst_data", out_data, 64'd0);
    check("arst_cnt", {57'd0, fill_cnt}, 64'd0);
    #1;
    rst_n = 1'b1;
    tick();
    check("arst_after_ready", {63'd0, in_ready}, 64'd1);

    // Randomized run with mixed modes, stalls and rare clears.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 127) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 3) != 0), 1'($urandom), 6'($urandom),
            ($urandom_range(0, 3) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
